// File: rtl/l1dcache.sv
`default_nettype none
// ==========================================================================
// l1dcache : direct-mapped, write-through, no-write-allocate L1 data cache
// Rev 1.0
// ==========================================================================
module l1dcache #(
  parameter int WIDTH      = 128,
  parameter int MASKW      = WIDTH/8,
  parameter int ADDR_WIDTH = 32,
  parameter int LINES      = 64,
  parameter int OFF_W      = $clog2(WIDTH/8),
  parameter int IDX_W      = $clog2(LINES),
  parameter int TAG_W      = ADDR_WIDTH-IDX_W-OFF_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [3:0]            req_wmask,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  output logic [31:0]           resp_rdata,
  output logic                  rw_valid,
  output logic                  rw_we,
  output logic [ADDR_WIDTH-1:0] rw_addr,
  output logic [MASKW-1:0]      w_mask,
  output logic [WIDTH-1:0]      w_data,
  output logic                  w_ce,
  input  logic [WIDTH-1:0]      r_data,
  input  logic                  rw_ready,
  input  logic                  inv_valid,
  input  logic [ADDR_WIDTH-1:0] inv_addr,
  output logic                  inv_ready
);
  localparam int WORD_W = OFF_W - 2;
  localparam int LANES  = WIDTH / 32;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CHECK = 2'd1,
    S_FILL  = 2'd2,
    S_WRITE = 2'd3
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [LINES-1:0] r_valid;
  logic [TAG_W-1:0] r_tag  [LINES];
  logic [WIDTH-1:0] r_line [LINES];

  logic                  r_we;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [3:0]            r_wmask;
  logic [31:0]           r_wdata;

  logic [IDX_W-1:0]      w_idx;
  logic [TAG_W-1:0]      w_tag;
  logic [WORD_W-1:0]     w_word;
  logic [IDX_W-1:0]      w_inv_idx;
  logic [TAG_W-1:0]      w_inv_tag;
  logic                  w_hit;
  logic                  w_accept;
  logic                  w_fill_done;
  logic                  w_write_done;
  logic                  w_inv_hit;
  logic [ADDR_WIDTH-1:0] w_line_addr;
  logic [MASKW-1:0]      w_lane_mask;
  logic [WIDTH-1:0]      w_merged;
  logic                  w_unused;

  assign w_idx        = r_addr[OFF_W +: IDX_W];
  assign w_tag        = r_addr[ADDR_WIDTH-1 -: TAG_W];
  assign w_word       = r_addr[OFF_W-1:2];
  assign w_inv_idx    = inv_addr[OFF_W +: IDX_W];
  assign w_inv_tag    = inv_addr[ADDR_WIDTH-1 -: TAG_W];
  assign w_hit        = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign w_accept     = req_valid && req_ready;
  assign w_fill_done  = (r_state == S_FILL) && rw_ready;
  assign w_write_done = (r_state == S_WRITE) && rw_ready;
  assign w_line_addr  = {r_addr[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
  assign w_lane_mask  = MASKW'(r_wmask) << {w_word, 2'b00};
  assign w_unused     = ^{r_addr[1:0], inv_addr[OFF_W-1:0]};

  // A fill landing in the same cycle as a matching invalidate must end up invalid.
  assign w_inv_hit = inv_ready &&
                     ((r_valid[w_inv_idx] && (r_tag[w_inv_idx] == w_inv_tag)) ||
                      (w_fill_done && (w_inv_idx == w_idx) && (w_inv_tag == w_tag)));

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    rw_valid = 1'b0;
    rw_we    = 1'b0;
    rw_addr  = '0;
    w_mask   = '0;
    w_data   = '0;
    w_ce     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_next = S_CHECK;
      end
      S_CHECK: begin
        if (r_we)        w_next = S_WRITE;
        else if (!w_hit) w_next = S_FILL;
        else             w_next = S_IDLE;
      end
      S_FILL: begin
        rw_valid = 1'b1;
        rw_addr  = w_line_addr;
        if (rw_ready) w_next = S_IDLE;
      end
      S_WRITE: begin
        rw_valid = 1'b1;
        rw_we    = 1'b1;
        w_ce     = 1'b1;
        rw_addr  = w_line_addr;
        w_mask   = w_lane_mask;
        w_data   = {LANES{r_wdata}};
        if (rw_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      req_ready  <= 1'b0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      inv_ready  <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wmask    <= '0;
      r_wdata    <= '0;
    end else begin
      req_ready  <= (w_next == S_IDLE);
      resp_valid <= 1'b0;
      inv_ready  <= inv_valid && !inv_ready;
      if (w_accept) begin
        r_we    <= req_we;
        r_addr  <= req_addr;
        r_wmask <= req_wmask;
        r_wdata <= req_wdata;
      end
      if ((r_state == S_CHECK) && !r_we && w_hit) begin
        resp_valid <= 1'b1;
        resp_rdata <= r_line[w_idx][{w_word, 5'd0} +: 32];
      end
      if (w_fill_done) begin
        resp_valid <= 1'b1;
        resp_rdata <= r_data[{w_word, 5'd0} +: 32];
      end
      if (w_write_done) begin
        resp_valid <= 1'b1;
        resp_rdata <= '0;
      end
    end
  end

  // Later assignment wins: an invalidate overrides a same-cycle fill.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= '0;
    end else begin
      if (w_fill_done) r_valid[w_idx] <= 1'b1;
      if (w_inv_hit)   r_valid[w_inv_idx] <= 1'b0;
    end
  end

  always_comb begin
    w_merged = r_line[w_idx];
    for (int b = 0; b < MASKW; b++) begin
      if (w_lane_mask[b]) w_merged[8*b +: 8] = r_wdata[8*(b%4) +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (w_fill_done) begin
        r_tag[w_idx]  <= w_tag;
        r_line[w_idx] <= r_data;
      end
      if (w_write_done && w_hit) r_line[w_idx] <= w_merged;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_l1dcache.sv
`default_nettype none
// tb_l1dcache : scoreboard bench for l1dcache with a hand-driven L2 provider
module tb_l1dcache;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic         req_we = 1'b0;
  logic [31:0]  req_addr = '0;
  logic [3:0]   req_wmask = '0;
  logic [31:0]  req_wdata = '0;
  logic         resp_valid;
  logic [31:0]  resp_rdata;
  logic         rw_valid;
  logic         rw_we;
  logic [31:0]  rw_addr;
  logic [15:0]  w_mask;
  logic [127:0] w_data;
  logic         w_ce;
  logic [127:0] r_data = '0;
  logic         rw_ready = 1'b0;
  logic         inv_valid = 1'b0;
  logic [31:0]  inv_addr = '0;
  logic         inv_ready;

  always #5 clk = ~clk;

  l1dcache dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wmask(req_wmask), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .rw_valid(rw_valid), .rw_we(rw_we), .rw_addr(rw_addr),
    .w_mask(w_mask), .w_data(w_data), .w_ce(w_ce),
    .r_data(r_data), .rw_ready(rw_ready),
    .inv_valid(inv_valid), .inv_addr(inv_addr), .inv_ready(inv_ready)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int accept_cyc = 0;
  int last_resp_cyc = 0;
  int rw_cycles = 0;
  logic [31:0]  exp_q[$];
  logic [127:0] mem [logic [31:0]];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Backing store of the provider; lines never written come from a fixed pattern.
  function automatic logic [127:0] line_of(input logic [31:0] la);
    if (mem.exists(la)) return mem[la];
    return {~la, la ^ 32'h3333_0000, la ^ 32'h2222_0000, la ^ 32'h1111_0000};
  endfunction

  function automatic logic [31:0] word_of(input logic [31:0] a);
    logic [127:0] l;
    l = line_of({a[31:4], 4'h0});
    return l[a[3:2]*32 +: 32];
  endfunction

  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (rw_valid) rw_cycles++;
      if (resp_valid) begin
        last_resp_cyc = cyc;
        if (exp_q.size() == 0) begin
          check("resp_unexpected", resp_valid, 1'b0);
        end else begin
          e = exp_q.pop_front();
          check("resp_rdata", resp_rdata, e);
        end
      end
    end
  end

  task automatic do_req(input logic we, input logic [31:0] addr, input logic [3:0] mask,
                        input logic [31:0] wd);
    int n = 0;
    while (!req_ready && n < 20) begin @(posedge clk); #1; n++; end
    check("req_ready", req_ready, 1'b1);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wmask = mask; req_wdata = wd;
    exp_q.push_back(we ? 32'h0 : word_of(addr));
    @(posedge clk); #1;
    accept_cyc = cyc - 1;
    req_valid = 1'b0;
    check("req_ready_drop", req_ready, 1'b0);
  endtask

  // mode 0: plain reply; 1: invalidate acked before rw_ready; 2: invalidate coincides with rw_ready
  task automatic serve_bus(input logic we, input logic [31:0] la, input logic [15:0] mask,
                           input logic [31:0] wd, input int mode, input logic [31:0] ia);
    int n = 0;
    logic [127:0] l;
    while (!rw_valid && n < 20) begin @(posedge clk); #1; n++; end
    check("rw_valid", rw_valid, 1'b1);
    check("rw_we", rw_we, we);
    check("rw_addr", rw_addr, la);
    check("w_ce", w_ce, we);
    if (we) begin
      check("w_mask", w_mask, mask);
      check("w_data", w_data, {4{wd}});
    end
    if (mode != 0) begin
      inv_addr = ia; inv_valid = 1'b1;
      @(posedge clk); #1;
      check("inv_ready_pulse", inv_ready, 1'b1);
      inv_valid = 1'b0;
      if (mode == 1) begin
        @(posedge clk); #1;
        check("inv_ready_low", inv_ready, 1'b0);
        check("rw_wait", rw_valid, 1'b1);
      end
    end
    r_data = we ? 128'h0 : line_of(la);
    rw_ready = 1'b1;
    @(posedge clk); #1;
    rw_ready = 1'b0; r_data = '0;
    check("rw_drop", rw_valid, 1'b0);
    if (we) begin
      l = line_of(la);
      for (int b = 0; b < 16; b++) if (mask[b]) l[8*b +: 8] = wd[8*(b%4) +: 8];
      mem[la] = l;
    end
  endtask

  task automatic wait_resp();
    int n = 0;
    while (exp_q.size() != 0 && n < 20) begin @(posedge clk); #1; n++; end
    check("resp_seen", exp_q.size(), 0);
  endtask

  task automatic load_miss(input logic [31:0] a, input int mode);
    do_req(1'b0, a, 4'h0, 32'h0);
    serve_bus(1'b0, {a[31:4], 4'h0}, 16'h0, 32'h0, mode, {a[31:4], 4'h0});
    wait_resp();
  endtask

  task automatic load_hit(input logic [31:0] a);
    int r0;
    r0 = rw_cycles;
    do_req(1'b0, a, 4'h0, 32'h0);
    wait_resp();
    check("hit_no_bus", rw_cycles, r0);
    check("hit_latency", last_resp_cyc - accept_cyc, 2);
  endtask

  task automatic store(input logic [31:0] a, input logic [3:0] m, input logic [31:0] d,
                       input logic [15:0] lane_mask, input int mode);
    do_req(1'b1, a, m, d);
    serve_bus(1'b1, {a[31:4], 4'h0}, lane_mask, d, mode, {a[31:4], 4'h0});
    wait_resp();
  endtask

  initial begin
    int n;
    mem[32'h1000] = {32'hCAFE_0003, 32'hCAFE_0002, 32'hDEAD_BEEF, 32'hCAFE_0000};
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", req_ready, 1'b0);
    check("rst_resp_valid", resp_valid, 1'b0);
    check("rst_resp_rdata", resp_rdata, 32'h0);
    check("rst_rw_valid", rw_valid, 1'b0);
    check("rst_rw_we", rw_we, 1'b0);
    check("rst_rw_addr", rw_addr, 32'h0);
    check("rst_w_mask", w_mask, 16'h0);
    check("rst_w_data", w_data, 128'h0);
    check("rst_w_ce", w_ce, 1'b0);
    check("rst_inv_ready", inv_ready, 1'b0);
    rst = 1'b0;

    load_miss(32'h1004, 0);                               // 0xDEADBEEF
    load_hit(32'h1004);
    store(32'h1008, 4'hF, 32'h1122_3344, 16'h0F00, 1);    // self-invalidated
    load_miss(32'h1008, 0);
    store(32'h1008, 4'h3, 32'h5566_7788, 16'h0300, 0);    // merged into cached line
    load_hit(32'h1008);

    inv_addr = 32'h1000; inv_valid = 1'b1;
    @(posedge clk); #1;
    check("idle_inv_pulse", inv_ready, 1'b1);
    @(posedge clk); #1;
    check("idle_inv_single", inv_ready, 1'b0);
    inv_valid = 1'b0;
    @(posedge clk); #1;
    check("idle_inv_after", inv_ready, 1'b0);
    load_miss(32'h1000, 0);

    inv_addr = 32'h2000; inv_valid = 1'b1;
    @(posedge clk); #1;
    check("other_tag_inv_pulse", inv_ready, 1'b1);
    inv_valid = 1'b0;
    @(posedge clk); #1;
    load_hit(32'h1004);

    store(32'h3000, 4'hF, 32'hA1B2_C3D4, 16'h000F, 0);    // store miss, no allocate
    load_miss(32'h3000, 0);
    load_miss(32'h5000, 2);                               // invalidate wins over fill
    load_miss(32'h5000, 0);

    do_req(1'b0, 32'h4000, 4'h0, 32'h0);
    n = 0;
    while (!rw_valid && n < 20) begin @(posedge clk); #1; n++; end
    check("fill_before_rst", rw_valid, 1'b1);
    rst = 1'b1; rw_ready = 1'b1; r_data = line_of(32'h4000);
    @(posedge clk); #1;
    rw_ready = 1'b0; r_data = '0;
    check("midrst_rw_valid", rw_valid, 1'b0);
    check("midrst_req_ready", req_ready, 1'b0);
    check("midrst_resp_valid", resp_valid, 1'b0);
    exp_q.delete();
    rst = 1'b0;
    load_miss(32'h3000, 0);

    repeat (3) @(posedge clk);
    #1;
    check("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/l1dcache.md
Name: l1dcache

Overview:
- Direct-mapped, write-through, no-write-allocate L1 data cache; the requester end of a SystemBus port.
- Accepts 32-bit load/store requests from the core pipeline.
- Issues line reads and masked line writes to the shared L2 provider.
- Services the provider's invalidation broadcasts so cached lines stay coherent with other ports.

Parameters:
- WIDTH, 128, bus/line width in bits.
- MASKW, WIDTH/8, bus byte-mask width.
- ADDR_WIDTH, 32, byte address width.
- LINES, 64, number of cache lines (power of two).
- OFF_W, $clog2(WIDTH/8), line byte-offset bits (derived).
- IDX_W, $clog2(LINES), index bits (derived).
- TAG_W, ADDR_WIDTH-IDX_W-OFF_W, tag bits (derived).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- req_valid  in  1  core request valid.
- req_ready  out  1  core request accepted this cycle.
- req_we  in  1  1=store, 0=load.
- req_addr  in  ADDR_WIDTH  byte address; bits[1:0] ignored.
- req_wmask  in  4  store byte enables.
- req_wdata  in  32  store data.
- resp_valid  out  1  one-cycle response pulse.
- resp_rdata  out  32  load data, valid with resp_valid.
- bus  SystemBus.consumer  -  signals rw_valid, rw_we, rw_addr, w_mask, w_data, w_ce, r_data, rw_ready, inv_valid, inv_addr, inv_ready.

Behaviour:
- Storage: valid[LINES], tag[LINES], data[LINES] held in flops. All valid bits clear on rst.
- Reset values:
  - req_ready=0, resp_valid=0, resp_rdata=0.
  - rw_valid=0, rw_we=0, rw_addr=0, w_mask=0, w_data=0, w_ce=0.
  - inv_ready=0, state=IDLE.
- State IDLE:
  - req_ready=1.
  - On req_valid, latch we/addr/wmask/wdata and go to CHECK.
- State CHECK (req_ready=0):
  - hit = valid[idx] && tag[idx]==addr tag.
  - Load hit: resp_valid=1 next cycle with the selected word (word = addr[OFF_W-1:2]); return to IDLE. Load-hit latency is 2 cycles from acceptance.
  - Load miss: go to FILL.
  - Store (hit or miss): go to WRITE.
- State FILL:
  - rw_valid=1, rw_we=0, rw_addr = line-aligned address (low OFF_W bits 0).
  - Hold all request fields stable until rw_ready.
  - On rw_ready: write r_data into data[idx], set tag, set valid, pulse resp_valid with the word from r_data next cycle, go to IDLE.
- State WRITE:
  - rw_valid=1, rw_we=1, w_ce=1, rw_addr line-aligned.
  - w_mask = req_wmask << (4*word).
  - w_data = req_wdata replicated to every 32-bit lane.
  - On rw_ready: if hit (re-evaluated against current valid/tag), merge the masked bytes into data[idx]. Pulse resp_valid next cycle (resp_rdata=0), go to IDLE.
  - Never allocate on store miss.
- rw_ready outside FILL/WRITE is ignored. rw_valid drops the cycle after rw_ready.
- Invalidation, independent of main state and active in every state:
  - inv_ready is registered: inv_ready <= inv_valid && !inv_ready, so the first observed cycle of inv_valid produces a one-cycle pulse.
  - In the cycle inv_ready=1: if valid[inv idx] && tag matches inv_addr tag, clear valid[inv idx].
  - Invalidations are acked while in WRITE. The provider broadcasts the writer's own store back to it, and withholds rw_ready until every port acks; failing to ack deadlocks.
- Self-invalidation of a just-written line is correct behaviour: a subsequent load misses and refetches.
- Simultaneous fill-complete and invalidate on the same index/tag: invalidate wins (valid=0). The core still receives the fill data.
- Simultaneous store-merge and invalidate on the same line: invalidate wins.
- rst mid-transaction: all outputs return to reset values the next cycle and rw_valid drops immediately. Any in-flight bus response is ignored.

Test Plan:
- Load 0x0000_1004 cold: bus rw_addr=0x1000, rw_we=0. Provider returns r_data with lane1=0xDEADBEEF → resp_rdata=0xDEADBEEF. Repeat the load: hit, no rw_valid, resp 2 cycles after accept.
- Store 0x0000_1008 data 0x11223344 mask 0xF after the fill:
  - Bus shows rw_we=1, w_ce=1, w_mask=0x0F00, w_data=0x11223344 in all lanes.
  - Provider invalidates 0x1000 before rw_ready; inv_ready pulses, then rw_ready arrives.
  - Next load 0x1008 misses.
- Same store with provider not invalidating: data merged; load 0x1008 hits and returns 0x11223344.
- inv_valid held 3 cycles for 0x1000 while idle: exactly one inv_ready pulse, one cycle after first assertion; line 0x1000 invalid. inv_addr 0x2000 (same index, other tag) leaves the line valid.
- Store miss to 0x3000: no allocation; subsequent load 0x3000 issues a bus read.
- rst asserted in FILL with rw_valid=1: next cycle rw_valid=0, req_ready=0, resp_valid=0. After rst release the first load misses.
